note_sprite_renderer: RTL and testbench
=======================================

# note_sprite_renderer

Parametrised note-sprite renderer for the VGA path. It draws NUM_NOTES note glyphs in a horizontal row from one shared, stacked sprite ROM and produces the final 24-bit pixel colour. It adds two things the fixed seven-glyph renderer does not have: a per-note highlight with a frame-counted hold-off after release, and colour-keyed transparency. It sits between the VGA timing generator (pos_x/pos_y) and the RGB output register.

## Interface
- NUM_NOTES, 7: number of glyphs; glyph i is the i-th sprite in the ROM.
- SPR_W, 32: sprite width in pixels; must be a power of two.
- SPR_H, 32: sprite height in pixels.
- X0, 112: left edge of glyph 0.
- X_STEP, 64: horizontal pitch between glyphs; must be ≥ SPR_W.
- Y0, 224: top edge of all glyphs.
- HOLD_FRAMES, 8: frames a highlight persists after note release; 0 disables the hold-off.
- BG_COLOR, 24'h000000: background colour.
- HL_COLOR, 24'hFFD700: colour of opaque pixels of a highlighted glyph.
- KEY_COLOR, 24'hFF00FF: ROM colour treated as transparent.
- vga_clk  in  1  pixel clock; the only clock. Reset is asynchronous and active-high.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1).
- pos_x  in  10  current pixel column.
- pos_y  in  10  current pixel row.
- note_on  in  NUM_NOTES  per-note pressed level; may be asynchronous to vga_clk.
- rom_addr  out  AW  sprite ROM address. AW = clog2(NUM_NOTES·SPR_W·SPR_H).
- rom_data  in  24  ROM read data; valid one edge after rom_addr.
- pos_data  out  24  final pixel colour.

## Operation
- **note_on synchroniser:** note_on passes through a 2-flop synchroniser; the result is called non_s.
- **Hit test (stage 1):**
  - dy = pos_y − Y0 and dx_i = pos_x − X0 − i·X_STEP, all modulo 2^10 and unsigned.
  - Glyph i hits when dy < SPR_H and dx_i < SPR_W. Negative offsets wrap to large values and therefore miss.
  - If several glyphs hit, the lowest index wins.
- **Stage 1 registers:**
  - hit_s1, idx_s1 and hl_s1, where hl_s1 is the highlight of the winning glyph.
  - rom_addr = idx·SPR_W·SPR_H + dy·SPR_W + dx_idx.
  - On a miss, rom_addr = 0.
- **Stage 2:** hit and hl are delayed one more register so they stay aligned with rom_data.
- **Output register, pos_data:**
  - Miss → BG_COLOR.
  - Hit with rom_data == KEY_COLOR → BG_COLOR.
  - Hit, opaque, highlighted → HL_COLOR.
  - Otherwise → rom_data.
- **Frame tick:** one cycle pulse when (pos_x, pos_y) == (0, 0) and the previous cycle's coordinate was not (0, 0). A coordinate that stalls at (0, 0) produces only one tick.
- **Hold counter per note, hl_cnt[i]** (width clog2(HOLD_FRAMES+1)):
  - non_s[i] = 1 → load HOLD_FRAMES; load has priority over decrement.
  - non_s[i] = 0 and tick and hl_cnt[i] ≠ 0 → decrement.
  - Otherwise hold.
- **Highlight:** highlight[i] = non_s[i] | (hl_cnt[i] ≠ 0).

## Timing
- **Latency:** coordinates sampled at edge k → rom_addr updated at k; rom_data valid after k+1; pos_data updated at edge k+2. Fixed latency of 2 edges after sampling; the timing generator delays its sync signals to match.
- **Throughput:** one pixel per clock, no stalls and no handshake.
- **note_on to visible highlight:** 2 synchroniser edges plus 3 pipeline edges.
- **Release:** the highlight stays on until HOLD_FRAMES ticks have occurred after the last cycle with non_s = 1. A tick in the same cycle as release does not decrement, because load wins.
- **Reset values while rst_n = 1 (asynchronous):**
  - rom_addr = 0, pos_data = 24'h000000.
  - hit and hl pipeline bits = 0.
  - Synchroniser flops = 0, hl_cnt = 0.
  - Previous-coordinate flag = "was (0, 0)", so no tick fires on the first cycle after release.
- **Reset mid-frame:** after deassertion the first pos_data values are BG_COLOR until the pipeline refills (2 edges). Highlight history is lost.

## Test plan
- **Single glyph, no highlight:** ROM holds pattern idx·1024 + addr; pos = (112, 224) → rom_addr = 0 and pos_data = ROM[0] two edges later. pos = (527, 255) → rom_addr = 6·1024 + 1023 = 7167.
- **Misses and wrap:** pos = (111, 224), (144, 224), (112, 223), (112, 256) and (0, 0) → pos_data = BG_COLOR and rom_addr = 0.
- **Transparency:** ROM word = KEY_COLOR inside glyph 3 → BG_COLOR. An adjacent opaque pixel returns its ROM value.
- **Highlight and hold:** assert note_on[2] for 10 cycles, then release, with HOLD_FRAMES = 8 → glyph 2's opaque pixels = HL_COLOR for exactly 8 further frame ticks, then revert to ROM data. Glyphs 0, 1 and 3–6 are unaffected.
- **Re-press during hold:** release note 4, wait 3 ticks, press again → counter reloads to 8 and the highlight is continuous. A tick coinciding with release does not decrement.
- **Reset mid-operation:** assert rst_n during an active glyph → pos_data = 0 and all counters = 0 immediately. After deassertion, BG_COLOR for 2 edges, then correct pixels.

Source files
------------

// File: rtl/note_sprite_renderer.sv
// Draws NUM_NOTES glyphs in a row from a stacked sprite ROM. Each glyph can be highlighted,
// with a frame-counted hold-off after release, and ROM words equal to KEY_COLOR are transparent.
module note_sprite_renderer #(
    parameter int          NUM_NOTES   = 7,
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          X0          = 112,
    parameter int          X_STEP      = 64,
    parameter int          Y0          = 224,
    parameter int          HOLD_FRAMES = 8,
    parameter logic [23:0] BG_COLOR    = 24'h000000,
    parameter logic [23:0] HL_COLOR    = 24'hFFD700,
    parameter logic [23:0] KEY_COLOR   = 24'hFF00FF,
    localparam int         AW          = $clog2(NUM_NOTES * SPR_W * SPR_H)
) (
    input  logic                 vga_clk,
    input  logic                 rst_n,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic [NUM_NOTES-1:0] note_on,
    output logic [AW-1:0]        rom_addr,
    input  logic [23:0]          rom_data,
    output logic [23:0]          pos_data
);

    localparam int CW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int IW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

    logic [NUM_NOTES-1:0] r_sync1;
    logic [NUM_NOTES-1:0] r_non_s;
    logic                 r_prev_zero;
    logic [CW-1:0]        r_hl_cnt [NUM_NOTES];

    logic                 w_at_zero;
    logic                 w_tick;
    logic [NUM_NOTES-1:0] w_highlight;

    logic [9:0]           w_dy;
    logic                 w_hit;
    logic [IW-1:0]        w_idx;
    logic [9:0]           w_dx_win;
    logic                 w_hl_win;
    logic [AW-1:0]        w_addr;

    logic [AW-1:0]        r_rom_addr;
    logic                 r_hit_s1;
    logic                 r_hl_s1;
    logic                 r_hit_s2;
    logic                 r_hl_s2;
    logic [23:0]          r_pos_data;

    // Frame tick fires on entry to (0,0); a coordinate stalled there ticks only once.
    assign w_at_zero = (pos_x == 10'd0) && (pos_y == 10'd0);
    assign w_tick    = w_at_zero && !r_prev_zero;

    // NOTE: every flop here is updated with <=, so each register samples the pre-edge value of
    // its neighbours and the two synchroniser stages really are two separate flops.
    always_ff @(posedge vga_clk or posedge rst_n) begin
        if (rst_n) begin
            r_sync1     <= '0;
            r_non_s     <= '0;
            r_prev_zero <= 1'b1;
        end else begin
            r_sync1     <= note_on;
            r_non_s     <= r_sync1;
            r_prev_zero <= w_at_zero;
        end
    end

    always_ff @(posedge vga_clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_NOTES; i++) r_hl_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                if (r_non_s[i])
                    r_hl_cnt[i] <= CW'(HOLD_FRAMES);
                else if (w_tick && (r_hl_cnt[i] != '0))
                    r_hl_cnt[i] <= r_hl_cnt[i] - CW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_NOTES; i++)
            w_highlight[i] = r_non_s[i] | (r_hl_cnt[i] != '0);
    end

    assign w_dy = pos_y - 10'(Y0);

    // Scan from the highest index down so the lowest-index hit is the one left standing.
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        logic [9:0] dx;
        w_hit    = 1'b0;
        w_idx    = '0;
        w_dx_win = '0;
        w_hl_win = 1'b0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            dx = pos_x - 10'(X0 + i * X_STEP);
            if ((w_dy < 10'(SPR_H)) && (dx < 10'(SPR_W))) begin
                w_hit    = 1'b1;
                w_idx    = IW'(i);
                w_dx_win = dx;
                w_hl_win = w_highlight[i];
            end
        end
    end

    assign w_addr = AW'(w_idx) * AW'(SPR_W * SPR_H) + AW'(w_dy) * AW'(SPR_W) + AW'(w_dx_win);

    always_ff @(posedge vga_clk or posedge rst_n) begin
        if (rst_n) begin
            r_rom_addr <= '0;
            r_hit_s1   <= 1'b0;
            r_hl_s1    <= 1'b0;
            r_hit_s2   <= 1'b0;
            r_hl_s2    <= 1'b0;
        end else begin
            r_rom_addr <= w_hit ? w_addr : '0;
            r_hit_s1   <= w_hit;
            r_hl_s1    <= w_hit & w_hl_win;
            r_hit_s2   <= r_hit_s1;
            r_hl_s2    <= r_hl_s1;
        end
    end

    always_ff @(posedge vga_clk or posedge rst_n) begin
        if (rst_n)
            r_pos_data <= 24'h000000;
        else if (!r_hit_s2 || (rom_data == KEY_COLOR))
            r_pos_data <= BG_COLOR;
        else if (r_hl_s2)
            r_pos_data <= HL_COLOR;
        else
            r_pos_data <= rom_data;
    end

    assign rom_addr = r_rom_addr;
    assign pos_data = r_pos_data;

endmodule

// File: tb/tb_note_sprite_renderer.sv
// Scoreboard bench for note_sprite_renderer: a geometric/frame-count model predicts each pixel,
// a monitor compares rom_addr and pos_data when each prediction falls due.
module tb_note_sprite_renderer;

    localparam int          N      = 7;
    localparam int          SPR_W  = 32;
    localparam int          SPR_H  = 32;
    localparam int          X0     = 112;
    localparam int          X_STEP = 64;
    localparam int          Y0     = 224;
    localparam int          HOLD   = 8;
    localparam logic [23:0] BG     = 24'h000000;
    localparam logic [23:0] HL     = 24'hFFD700;
    localparam logic [23:0] KEY    = 24'hFF00FF;
    localparam int          AW     = $clog2(N * SPR_W * SPR_H);

    logic          vga_clk = 1'b0;
    logic          rst_n   = 1'b1;
    logic [9:0]    pos_x   = '0;
    logic [9:0]    pos_y   = '0;
    logic [N-1:0]  note_on = '0;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_data = '0;
    logic [23:0]   pos_data;

    logic [23:0]   rom [0:(1<<AW)-1];

    typedef struct {
        int          due;
        logic [23:0] val;
    } exp_t;

    exp_t q_addr[$];
    exp_t q_pix[$];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    // Reference state: synchronised level and number of frame ticks seen since the note was last
    // seen pressed (saturating at HOLD, which also means "no hold active").
    logic [N-1:0] m_sync1;
    logic [N-1:0] m_non_s;
    int           m_ticks [N];
    bit           m_prev_zero;

    note_sprite_renderer dut (
        .vga_clk  (vga_clk),
        .rst_n    (rst_n),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .note_on  (note_on),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pos_data (pos_data)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        rom_data <= rom[rom_addr];
        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    always @(negedge vga_clk) begin
        exp_t e;
        if (!rst_n) begin
            if (q_addr.size() > 0 && q_addr[0].due == edge_cnt) begin
                e = q_addr.pop_front();
                check("rom_addr", 24'(rom_addr), e.val);
            end
            if (q_pix.size() > 0 && q_pix[0].due == edge_cnt) begin
                e = q_pix.pop_front();
                check("pos_data", pos_data, e.val);
            end
        end
    end

    task automatic model_reset();
        m_sync1     = '0;
        m_non_s     = '0;
        m_prev_zero = 1'b1;
        for (int i = 0; i < N; i++) m_ticks[i] = HOLD;
    endtask

    // One pixel clock: apply inputs, predict the responses, then advance the model over the edge.
    task automatic step(input int x, input int y, input logic [N-1:0] non);
        int          due;
        bit          hit;
        int          g;
        int          addr;
        logic [23:0] pix;
        bit          tick;
        @(negedge vga_clk);
        pos_x   = 10'(x);
        pos_y   = 10'(y);
        note_on = non;
        due     = edge_cnt + 1;
        hit     = 1'b0;
        g       = 0;
        for (int i = 0; i < N; i++) begin
            if (!hit && x >= X0 + i * X_STEP && x < X0 + i * X_STEP + SPR_W &&
                y >= Y0 && y < Y0 + SPR_H) begin
                hit = 1'b1;
                g   = i;
            end
        end
        addr = hit ? g * SPR_W * SPR_H + (y - Y0) * SPR_W + (x - X0 - g * X_STEP) : 0;
        if (!hit || rom[addr] == KEY)               pix = BG;
        else if (m_non_s[g] || m_ticks[g] < HOLD)   pix = HL;
        else                                        pix = rom[addr];
        q_addr.push_back('{due, 24'(addr)});
        q_pix.push_back('{due + 2, pix});
        tick = (x == 0 && y == 0) && !m_prev_zero;
        for (int i = 0; i < N; i++) begin
            if (m_non_s[i])                     m_ticks[i] = 0;
            else if (tick && m_ticks[i] < HOLD) m_ticks[i]++;
        end
        m_non_s     = m_sync1;
        m_sync1     = non;
        m_prev_zero = (x == 0 && y == 0);
    endtask

    function automatic int rand_x();
        return $urandom_range(100, 560);
    endfunction

    function automatic int rand_y();
        return $urandom_range(216, 262);
    endfunction

    task automatic frame(input logic [N-1:0] non, input int stall, input int len);
        repeat (stall) step(0, 0, non);
        repeat (len) step(rand_x(), rand_y(), non);
    endtask

    // Release reset just after an edge; the pipeline must show BG_COLOR for two edges.
    task automatic release_reset();
        @(posedge vga_clk);
        #1 rst_n = 1'b0;
        model_reset();
        q_pix.push_back('{edge_cnt + 1, BG});
        q_pix.push_back('{edge_cnt + 2, BG});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] cur;
        for (int a = 0; a < (1 << AW); a++) begin
            rom[a] = 24'($urandom);
            if (rom[a] == KEY || rom[a] == HL) rom[a] = 24'h00A5A5;
            if ((a % 11) == 5) rom[a] = KEY;
        end
        rom[0]    = 24'h102030;
        rom[7167] = 24'hC0FFEE;
        rom[3269] = KEY;          // glyph 3, (dx=5, dy=6)
        rom[3270] = 24'h123456;   // its opaque neighbour
        model_reset();

        repeat (3) @(negedge vga_clk);
        check("reset_pos_data", pos_data, 24'h000000);
        check("reset_rom_addr", 24'(rom_addr), 24'h000000);
        release_reset();

        // Corners, misses, wrap-around and transparency.
        step(112, 224, '0);
        step(527, 255, '0);
        step(111, 224, '0);
        step(144, 224, '0);
        step(112, 223, '0);
        step(112, 256, '0);
        step(0, 0, '0);
        step(309, 230, '0);
        step(310, 230, '0);
        step(1023, 1023, '0);
        step(496, 224, '0);
        step(175, 240, '0);

        // Highlight of note 2 with hold-off, including stalled (0,0) frames.
        frame('0, 1, 20);
        frame(N'(1 << 2), 1, 4);
        repeat (10) step(112 + 2 * X_STEP + $urandom_range(0, 31), rand_y(), N'(1 << 2));
        for (int f = 0; f < 12; f++) frame('0, 1 + (f % 3), 20);

        // Note 4: release, 3 ticks, re-press; vary where release lands relative to the tick.
        for (int off = 0; off < 4; off++) begin
            repeat (5) step(rand_x(), rand_y(), N'(1 << 4));
            repeat (off) step(rand_x(), rand_y(), '0);
            frame('0, 1, 15);
            frame('0, 1, 15);
            frame('0, 1, 15);
            frame(N'(1 << 4), 1, 15);
        end
        for (int f = 0; f < 10; f++) frame('0, 1, 18);

        // Reset in the middle of a highlighted glyph.
        repeat (8) step(112 + 5 * X_STEP + 10, 240, N'(1 << 5));
        @(negedge vga_clk);
        #2 rst_n = 1'b1;
        #1;
        check("midreset_pos_data", pos_data, 24'h000000);
        check("midreset_rom_addr", 24'(rom_addr), 24'h000000);
        q_addr.delete();
        q_pix.delete();
        note_on = '0;
        repeat (3) @(negedge vga_clk);
        release_reset();
        for (int f = 0; f < 3; f++) frame('0, 1, 20);

        // Randomised traffic.
        cur = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) cur[$urandom_range(0, N - 1)] ^= 1'b1;
            case ($urandom_range(0, 19))
                0:       repeat ($urandom_range(1, 3)) step(0, 0, cur);
                1:       step($urandom_range(0, 1023), $urandom_range(0, 1023), cur);
                default: step(rand_x(), rand_y(), cur);
            endcase
        end
        for (int f = 0; f < 10; f++) frame('0, 1, 15);

        repeat (4) @(negedge vga_clk);
        check("drain_addr_queue", 24'(q_addr.size()), 24'd0);
        check("drain_pix_queue", 24'(q_pix.size()), 24'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
